prim_sky130_ram_1p_banked: RTL and testbench
============================================

Name: prim_sky130_ram_1p_banked

Overview:
Parametrised successor to the sky130 single-port RAM primitive. It splits Depth across NumBanks `la_spram` macros and adds a req/gnt handshake with an explicit read-valid. It also contains a zeroization FSM that clears every word after reset or on request. It sits under the `prim_ram_1p` abstraction wherever a RAM larger than one macro, or a scrubbed RAM, is needed.

Parameters:
- Width, 32: data bits per word.
- Depth, 512: total words; power of two; multiple of NumBanks.
- NumBanks, 4: number of `la_spram` instances; power of two, >=1.
- DataBitsPerMask, 8: data bits per write-mask bit; Width must be a multiple of it.
- Derived, localparam Aw = $clog2(Depth): address width.
- Derived, localparam Bw = $clog2(NumBanks): bank-select width (0 when NumBanks=1).
- Derived, localparam Mw = Width/DataBitsPerMask: mask width.
- Derived, localparam Bd = Depth/NumBanks: words per bank.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle.
- write_i  in  1  1=write, 0=read; sampled when req_i & gnt_o.
- addr_i  in  Aw  word address.
- wdata_i  in  Width  write data.
- wmask_i  in  Mw  write mask; bit k enables data bits [k*DataBitsPerMask +: DataBitsPerMask].
- rvalid_o  out  1  read data valid.
- rdata_o  out  Width  read data.
- init_req_i  in  1  pulse to re-zeroize the whole RAM.
- init_busy_o  out  1  zeroization in progress.
- cfg_i  in  ram_1p_cfg_t  macro config; passed through, unused.

Behaviour:
- Banking:
  - Bank select = addr_i[Aw-1 -: Bw]; bank address = addr_i[Aw-Bw-1:0].
  - Each bank is an `la_spram` with DW=Width, AW=Aw-Bw.
  - On a granted access only the selected bank sees ce=1.
- Mask: wmask_i bits are replicated DataBitsPerMask times to a Width-bit macro mask. A write with an all-zero mask is granted but leaves memory unchanged.
- FSM states:
  - INIT: counter ctr drives all banks in parallel with ce=1, we=1, full mask, din=0. ctr increments 0..Bd-1. At ctr=Bd-1, next state is IDLE and ctr returns to 0.
  - IDLE: normal accesses. init_req_i=1 moves to INIT next cycle with ctr=0.
- Reset: state=INIT, ctr=0, rvalid_o=0, rdata_o=0, init_busy_o=1, gnt_o=0. After reset deassertion, zeroization runs automatically: Bd cycles, then IDLE.
- init_busy_o = (state==INIT); combinational from state.
- Grant: gnt_o = req_i & (state==IDLE) & ~init_req_i, combinational. If req_i and init_req_i are both high in IDLE, init wins: gnt_o=0 and the request is dropped; the requester must hold req_i until granted.
- Read latency: 1 cycle. A granted read at cycle N gives rvalid_o=1 and valid rdata_o at N+1.
  - The read bank index is registered at grant; rdata_o = dout of that bank when rvalid_o=1, else 0.
  - Writes never assert rvalid_o.
- Back-to-back: a grant every cycle in IDLE. Read after write to the same address returns the new data.
- init_req_i during INIT is ignored (no restart).
- Asynchronous reset mid-INIT or mid-read: state returns to INIT with ctr=0, rvalid_o drops to 0, and the in-flight read is discarded.
- Reads in INIT are not possible, since gnt_o=0.

Optional Feature:
- Macro: PRIM_RAM_1P_OUTREG_EN.
- Defined:
  - Adds an output register stage: rdata_o and rvalid_o are registered one more time, so read latency is 2 cycles.
  - The extra registers reset to 0.
  - Throughput is unchanged: one read per cycle, fully pipelined.
  - A reset or init_req_i flushes both stages.
- Undefined: latency is 1 cycle as above.

Test Plan (Width=32, Depth=512, NumBanks=4, DataBitsPerMask=8):
- Reset release: hold req_i=1 → gnt_o=0 and init_busy_o=1 for exactly 128 cycles, then gnt_o=1. A read of 0x1FF then returns 0x00000000 with rvalid_o one cycle later.
- Bank coverage: write 0xA5A5_0000+i to addresses 0x000, 0x080, 0x100, 0x180, then read each → data matches and other banks are untouched.
- Byte mask: write 0xFFFFFFFF to 0x005, then write 0x11223344 with mask 4'b0101, then read → 0xFF22FF44.
- Collision: in IDLE, assert req_i=1 and init_req_i=1 together → gnt_o=0. After 128 busy cycles, a read of a previously written address returns 0.
- Reset mid-init: assert rst_ni=0 at init cycle 60, then release → full 128-cycle init restarts from 0 and rvalid_o stays 0 throughout.
- Back-to-back reads of 0x003, then 0x083, every cycle → consecutive rvalid_o with the correct data in order. With PRIM_RAM_1P_OUTREG_EN, the same sequence is shifted by one more cycle.

Source files
------------

// File: rtl/prim_sky130_ram_1p_banked.sv
// Banked single-port RAM for sky130 built from NumBanks la_spram-style macros.
// Adds a req/gnt handshake with an explicit read-valid and a zeroization FSM
// that clears every word after reset or on init_req_i.
// Optional: define PRIM_RAM_1P_OUTREG_EN for an extra output register stage,
// which gives a 2-cycle read latency.

`timescale 1ns / 1ps

package prim_ram_1p_pkg;
  // Macro configuration word. The sky130 macros ignore it.
  typedef struct packed {
    logic       cfg_en;
    logic [3:0] cfg;
  } ram_1p_cfg_t;
endpackage

module prim_sky130_ram_1p_banked
  import prim_ram_1p_pkg::*;
#(
  parameter int unsigned Width           = 32,
  parameter int unsigned Depth           = 512,
  parameter int unsigned NumBanks        = 4,
  parameter int unsigned DataBitsPerMask = 8,
  localparam int unsigned Aw             = $clog2(Depth),
  localparam int unsigned Bw             = $clog2(NumBanks),
  localparam int unsigned Mw             = Width / DataBitsPerMask,
  localparam int unsigned Bd             = Depth / NumBanks
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              write_i,
  input  logic [Aw-1:0]     addr_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic [Mw-1:0]     wmask_i,
  output logic              rvalid_o,
  output logic [Width-1:0]  rdata_o,
  input  logic              init_req_i,
  output logic              init_busy_o,
  input  ram_1p_cfg_t       cfg_i
);

  // Bank-local address width and a bank-select width that never collapses to zero.
  localparam int unsigned Baw = Aw - Bw;
  localparam int unsigned Sw  = (Bw > 0) ? Bw : 1;

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StIdle = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [Baw-1:0] ctr_q, ctr_d;
  logic           in_idle;

  // Configuration is carried for interface compatibility only.
  logic unused_cfg;
  assign unused_cfg = ^cfg_i;

  assign in_idle     = (state_q == StIdle);
  assign init_busy_o = (state_q == StInit);
  // A simultaneous init request beats the access; the requester has to retry.
  assign gnt_o       = req_i & in_idle & ~init_req_i;

  // Zeroization sweep: INIT walks ctr over every bank row, IDLE waits for init_req_i.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      StInit: begin
        if (ctr_q == Baw'(Bd - 1)) begin
          state_d = StIdle;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      StIdle: begin
        if (init_req_i) begin
          state_d = StInit;
          ctr_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        ctr_d   = '0;
      end
    endcase
  end

  // FSM state and sweep counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Widen the per-byte mask into a per-bit macro mask.
  logic [Width-1:0] bit_mask;
  for (genvar k = 0; k < Mw; k++) begin : g_mask
    assign bit_mask[k*DataBitsPerMask +: DataBitsPerMask] = {DataBitsPerMask{wmask_i[k]}};
  end

  logic [Sw-1:0]  bank_sel;
  logic [Baw-1:0] bank_addr;

  if (Bw > 0) begin : g_sel
    assign bank_sel = addr_i[Aw-1 -: Bw];
  end else begin : g_nosel
    assign bank_sel = '0;
  end
  assign bank_addr = addr_i[Baw-1:0];

  // Macro port signals. Address, data, mask and write-enable are shared by all banks;
  // only chip-enable is per bank.
  logic [NumBanks-1:0] mac_ce;
  logic                mac_we;
  logic [Baw-1:0]      mac_addr;
  logic [Width-1:0]    mac_din;
  logic [Width-1:0]    mac_mask;

  // INIT drives every bank in parallel with zeros; IDLE routes only the granted access.
  always_comb begin
    mac_ce   = '0;
    mac_we   = 1'b0;
    mac_addr = bank_addr;
    mac_din  = wdata_i;
    mac_mask = bit_mask;
    if (init_busy_o) begin
      mac_ce   = '1;
      mac_we   = 1'b1;
      mac_addr = ctr_q;
      mac_din  = '0;
      mac_mask = '1;
    end else begin
      mac_we = write_i;
      for (int unsigned b = 0; b < NumBanks; b++) begin
        mac_ce[b] = gnt_o & (bank_sel == Sw'(b));
      end
    end
  end

  logic [Width-1:0] bank_dout [NumBanks];

  // Each bank behaves like one la_spram macro (DW=Width, AW=Baw).
  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [Width-1:0] mem [Bd];
    logic [Width-1:0] dout;

    // Synchronous macro port: bit-masked write, or registered read. The array is not reset.
    always_ff @(posedge clk_i) begin
      if (mac_ce[b]) begin
        if (mac_we) begin
          mem[mac_addr] <= (mem[mac_addr] & ~mac_mask) | (mac_din & mac_mask);
        end else begin
          dout <= mem[mac_addr];
        end
      end
    end

    assign bank_dout[b] = dout;
  end

  logic          rd_valid_q;
  logic [Sw-1:0] rd_bank_q;
  logic          rd_fire;

  assign rd_fire = gnt_o & ~write_i;

  // Remember which bank a granted read targets so its dout can be steered out next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_bank_q <= bank_sel;
      end
    end
  end

  logic [Width-1:0] rd_data;
  assign rd_data = rd_valid_q ? bank_dout[rd_bank_q] : '0;

`ifdef PRIM_RAM_1P_OUTREG_EN
  logic             out_valid_q;
  logic [Width-1:0] out_data_q;

  // Extra output stage. An init request in IDLE flushes it; stage 1 is already empty
  // because nothing is granted in that cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (init_req_i && in_idle) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rd_valid_q;
      out_data_q  <= rd_data;
    end
  end

  assign rvalid_o = out_valid_q;
  assign rdata_o  = out_data_q;
`else
  assign rvalid_o = rd_valid_q;
  assign rdata_o  = rd_data;
`endif

endmodule

// File: tb/tb_prim_sky130_ram_1p_banked.sv
// Self-checking bench for prim_sky130_ram_1p_banked (32x512, 4 banks, byte mask).
// Reference: a flat 512-word array updated byte-by-byte, plus a queue of reads
// that are due on a given cycle.

`timescale 1ns / 1ps

module tb_prim_sky130_ram_1p_banked;
  import prim_ram_1p_pkg::*;

`ifdef PRIM_RAM_1P_OUTREG_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif
  localparam int unsigned InitCycles = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic        write = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        init_req = 1'b0;
  logic        init_busy;
  ram_1p_cfg_t cfg = '0;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic [31:0] model [512];

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  prim_sky130_ram_1p_banked #(
    .Width          (32),
    .Depth          (512),
    .NumBanks       (4),
    .DataBitsPerMask(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .gnt_o      (gnt),
    .write_i    (write),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .wmask_i    (wmask),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .init_req_i (init_req),
    .init_busy_o(init_busy),
    .cfg_i      (cfg)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 512; i++) model[i] = '0;
  endtask

  // Drives one request until granted; returns grant status and, for reads, the read result.
  task automatic access(input logic w, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic got_gnt, output logic v,
                        output logic [31:0] rd);
    @(posedge clk); #1;
    req = 1'b1; write = w; addr = a; wdata = d; wmask = m;
    got_gnt = 1'b0;
    for (int i = 0; i < 300 && !got_gnt; i++) begin
      @(negedge clk);
      got_gnt = gnt;
      if (!got_gnt) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    req = 1'b0; write = 1'b0;
    if (got_gnt && w) model[a] = merge(model[a], d, m);
    v = 1'b0;
    rd = '0;
    if (!w) begin
      repeat (Lat - 1) @(posedge clk);
      @(negedge clk);
      v = rvalid;
      rd = rdata;
    end
  endtask

  task automatic test_reset();
    int unsigned cycles;
    logic gnt_seen, valid_seen;
    req = 1'b1; write = 1'b0; addr = 9'h1FF;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0b want 0", gnt); end
    n_tests++;
    if (init_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0b want 1", init_busy); end
    n_tests++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b want 0", rvalid); end
    n_tests++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %08h want 0", rdata); end
    rst_n = 1'b1;
    #1;
    cycles = 0; gnt_seen = 0; valid_seen = 0;
    while (init_busy && cycles < 1000) begin
      if (gnt) gnt_seen = 1;
      if (rvalid) valid_seen = 1;
      cycles++;
      @(negedge clk);
    end
    n_tests++;
    if (cycles != InitCycles) begin
      n_fail++; $display("FAIL reset_init_len: got %0d want %0d", cycles, InitCycles);
    end
    n_tests++;
    if (gnt_seen || valid_seen) begin
      n_fail++; $display("FAIL reset_init_quiet: got gnt=%0b rvalid=%0b want 0 0", gnt_seen, valid_seen);
    end
    n_tests++;
    if (gnt !== 1'b1) begin n_fail++; $display("FAIL reset_first_gnt: got %0b want 1", gnt); end
    model_clear();
    @(posedge clk); #1;
    req = 1'b0;
    repeat (Lat - 1) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_read_1ff: got v=%0b d=%08h want v=1 d=00000000", rvalid, rdata);
    end
  endtask

  task automatic test_banks();
    logic g, v;
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 9'(i * 128), 32'hA5A5_0000 + 32'(i), 4'hF, g, v, rd);
    end
    for (int i = 0; i < 4; i++) begin
      for (int off = 0; off < 2; off++) begin
        logic [8:0] a;
        a = 9'(i * 128 + off);
        access(1'b0, a, '0, '0, g, v, rd);
        n_tests++;
        if (!g || v !== 1'b1 || rd !== model[a]) begin
          n_fail++;
          $display("FAIL bank_read @%03h: got g=%0b v=%0b d=%08h want 1 1 %08h", a, g, v, rd, model[a]);
        end
      end
    end
    n_tests++;
    if (model[9'h080] !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL bank_model: got %08h want a5a50001", model[9'h080]);
    end
  endtask

  task automatic test_mask();
    logic g, v;
    logic [31:0] rd;
    access(1'b1, 9'h005, 32'hFFFF_FFFF, 4'hF, g, v, rd);
    access(1'b1, 9'h005, 32'h1122_3344, 4'b0101, g, v, rd);
    access(1'b0, 9'h005, '0, '0, g, v, rd);
    n_tests++;
    if (v !== 1'b1 || rd !== 32'hFF22_FF44) begin
      n_fail++; $display("FAIL mask_0101: got v=%0b d=%08h want 1 ff22ff44", v, rd);
    end
    access(1'b1, 9'h005, 32'h0000_0000, 4'b0000, g, v, rd);
    n_tests++;
    if (!g) begin n_fail++; $display("FAIL mask_zero_gnt: got 0 want 1"); end
    access(1'b0, 9'h005, '0, '0, g, v, rd);
    n_tests++;
    if (v !== 1'b1 || rd !== 32'hFF22_FF44) begin
      n_fail++; $display("FAIL mask_zero_keep: got v=%0b d=%08h want 1 ff22ff44", v, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic g, v;
    logic [31:0] rd, d3, d83;
    d3 = $urandom;
    d83 = $urandom;
    access(1'b1, 9'h003, d3, 4'hF, g, v, rd);
    access(1'b1, 9'h083, d83, 4'hF, g, v, rd);
    for (int j = 0; j <= int'(Lat) + 2; j++) begin
      logic expv;
      logic [31:0] expd;
      @(posedge clk); #1;
      req = (j < 2);
      write = 1'b0;
      addr = (j == 0) ? 9'h003 : 9'h083;
      @(negedge clk);
      n_tests++;
      if (gnt !== (j < 2)) begin
        n_fail++; $display("FAIL b2b_gnt[%0d]: got %0b want %0b", j, gnt, (j < 2));
      end
      expv = (j == int'(Lat)) || (j == int'(Lat) + 1);
      expd = (j == int'(Lat)) ? d3 : d83;
      n_tests++;
      if (rvalid !== expv || (expv && rdata !== expd)) begin
        n_fail++;
        $display("FAIL b2b_rd[%0d]: got v=%0b d=%08h want v=%0b d=%08h", j, rvalid, rdata, expv, expd);
      end
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    int unsigned n = 400;
    q.delete();
    for (int unsigned j = 0; j < n + Lat; j++) begin
      logic expg;
      @(posedge clk); #1;
      expg = 1'b0;
      if (j < n && $urandom_range(0, 3) != 0) begin
        req = 1'b1;
        write = $urandom_range(0, 1) == 1;
        addr = {2'($urandom_range(0, 3)), 4'b0000, 3'($urandom_range(0, 7))};
        wdata = $urandom;
        wmask = 4'($urandom_range(0, 15));
        expg = 1'b1;
        if (write) model[addr] = merge(model[addr], wdata, wmask);
        else q.push_back('{due: j + Lat, data: model[addr]});
      end else begin
        req = 1'b0;
        write = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if (gnt !== expg) begin
        n_fail++; $display("FAIL rand_gnt[%0d]: got %0b want %0b", j, gnt, expg);
      end
      n_tests++;
      if (q.size() > 0 && q[0].due == j) begin
        if (rvalid !== 1'b1 || rdata !== q[0].data) begin
          n_fail++;
          $display("FAIL rand_rd[%0d]: got v=%0b d=%08h want v=1 d=%08h", j, rvalid, rdata, q[0].data);
        end
        void'(q.pop_front());
      end else if (rvalid !== 1'b0) begin
        n_fail++; $display("FAIL rand_idle[%0d]: got rvalid=%0b want 0", j, rvalid);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_collision();
    logic g, v;
    logic [31:0] rd;
    int unsigned cycles;
    logic gnt_seen;
    access(1'b1, 9'h010, 32'hDEAD_BEEF, 4'hF, g, v, rd);
    @(posedge clk); #1;
    req = 1'b1; write = 1'b0; addr = 9'h010; init_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt !== 1'b0) begin n_fail++; $display("FAIL coll_gnt: got %0b want 0", gnt); end
    @(posedge clk); #1;
    init_req = 1'b0;
    cycles = 0; gnt_seen = 0;
    while (init_busy && cycles < 1000) begin
      if (gnt) gnt_seen = 1;
      cycles++;
      // A re-init request in the middle of INIT must not restart the sweep.
      init_req = (cycles == 50);
      @(posedge clk); #1;
    end
    init_req = 1'b0;
    model_clear();
    n_tests++;
    if (cycles != InitCycles || gnt_seen) begin
      n_fail++; $display("FAIL coll_init_len: got %0d gnt=%0b want %0d gnt=0", cycles, gnt_seen, InitCycles);
    end
    n_tests++;
    if (gnt !== 1'b1) begin n_fail++; $display("FAIL coll_regnt: got %0b want 1", gnt); end
    @(posedge clk); #1;
    req = 1'b0;
    repeat (Lat - 1) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL coll_cleared: got v=%0b d=%08h want 1 00000000", rvalid, rdata);
    end
  endtask

  task automatic test_reset_mid_init();
    logic g, v;
    logic [31:0] rd;
    int unsigned cycles;
    logic valid_seen;
    access(1'b1, 9'h003, 32'h0BAD_F00D, 4'hF, g, v, rd);
    // Reset right after a read is granted: the read must never show up.
    @(posedge clk); #1;
    req = 1'b1; write = 1'b0; addr = 9'h003;
    @(negedge clk);
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL midread_rvalid: got %0b want 0", rvalid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (init_busy !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL midinit_state: got busy=%0b v=%0b want 1 0", init_busy, rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycles = 0; valid_seen = 0;
    while (init_busy && cycles < 1000) begin
      if (rvalid) valid_seen = 1;
      cycles++;
      @(negedge clk);
    end
    model_clear();
    n_tests++;
    if (cycles != InitCycles || valid_seen) begin
      n_fail++; $display("FAIL midinit_len: got %0d v=%0b want %0d v=0", cycles, valid_seen, InitCycles);
    end
    access(1'b0, 9'h003, '0, '0, g, v, rd);
    n_tests++;
    if (!g || v !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL midinit_cleared: got g=%0b v=%0b d=%08h want 1 1 0", g, v, rd);
    end
  endtask

  initial begin
    test_reset();
    test_banks();
    test_mask();
    test_back_to_back();
    test_random();
    test_collision();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
